// File: rtl/fbw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fbw_pkg : shared FSM encoding, record layout and resolve codes             |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package fbw_pkg;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_POP        = 3'd1;
  localparam logic [2:0] S_LATCH      = 3'd2;
  localparam logic [2:0] S_REQ        = 3'd3;
  localparam logic [2:0] S_WAIT_CMPLT = 3'd4;
  localparam logic [2:0] S_RECOVER    = 3'd5;

  // Record fields are numbered MSB-first; these are the last bit of each field.
  localparam int LINE_END_BIT    = 15;
  localparam int COL_END_BIT     = 31;
  localparam int COLOR_START_BIT = 32;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_OK,
    RES_RETRY,
    RES_DROP
  } resolve_e;

  // Converts the MSB-first index of a field's last bit into its LSB position.
  function automatic int lsb_of(input int rec_w, input int last_bit_msb0);
    return rec_w - 1 - last_bit_msb0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_mc_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_mc_writer_if : PLB master IPIF signal bundle (writer = master side)     |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
interface fb_mc_writer_if #(
  parameter int C_MST_AWIDTH = 32,
  parameter int C_MST_DWIDTH = 32
);
  logic                      IP2Bus_MstRd_Req;
  logic                      IP2Bus_MstWr_Req;
  logic [C_MST_AWIDTH-1:0]   IP2Bus_Mst_Addr;
  logic [C_MST_DWIDTH/8-1:0] IP2Bus_Mst_BE;
  logic                      IP2Bus_Mst_Lock;
  logic                      IP2Bus_Mst_Reset;
  logic                      Bus2IP_Mst_CmdAck;
  logic                      Bus2IP_Mst_Cmplt;
  logic                      Bus2IP_Mst_Error;
  logic                      Bus2IP_Mst_Rearbitrate;
  logic                      Bus2IP_Mst_Cmd_Timeout;
  logic [C_MST_DWIDTH-1:0]   Bus2IP_MstRd_d;
  logic                      Bus2IP_MstRd_src_rdy_n;
  logic [C_MST_DWIDTH-1:0]   IP2Bus_MstWr_d;
  logic                      Bus2IP_MstWr_dst_rdy_n;

  modport master (
    output IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
           IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d,
    input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
           Bus2IP_Mst_Rearbitrate, Bus2IP_Mst_Cmd_Timeout, Bus2IP_MstRd_d,
           Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n
  );

  modport slave (
    input  IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
           IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d,
    output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
           Bus2IP_Mst_Rearbitrate, Bus2IP_Mst_Cmd_Timeout, Bus2IP_MstRd_d,
           Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n
  );
endinterface
`default_nettype wire

// File: rtl/fbw_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fbw_rr_arbiter : combinational round-robin pick, first request after ptr  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module fbw_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NUM_CH);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    grant[idx] = any;
  end

endmodule
`default_nettype wire

// File: rtl/fb_mc_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fb_mc_writer : round-robin multi-FIFO pixel writer onto the PLB master IPIF|
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module fb_mc_writer
  import fbw_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int REC_W        = 96,
  parameter int LINE_LEN     = 9,
  parameter int COL_LEN      = 10,
  parameter int C_MST_AWIDTH = 32,
  parameter int C_MST_DWIDTH = 32,
  parameter logic [C_MST_AWIDTH-LINE_LEN-COL_LEN-3:0] FB_BASE_ADDR = 11'b1001_0000_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                     PLB_clk,
  input  logic                     reset,
  input  logic [NUM_CH*REC_W-1:0]  fifo_data,
  input  logic [NUM_CH-1:0]        fifo_empty,
  output logic [NUM_CH-1:0]        fifo_rd_en,
  fb_mc_writer_if.master           plb,
  output logic [15:0]              pix_count,
  output logic [15:0]              drop_count,
  output logic [2:0]               state
);

  localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RTY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int LINE_LSB  = lsb_of(REC_W, LINE_END_BIT);
  localparam int COL_LSB   = lsb_of(REC_W, COL_END_BIT);
  localparam int COLOR_LSB = lsb_of(REC_W, COLOR_START_BIT + C_MST_DWIDTH - 1);

  logic [LINE_LEN-1:0]     ch_line  [NUM_CH];
  logic [COL_LEN-1:0]      ch_col   [NUM_CH];
  logic [C_MST_DWIDTH-1:0] ch_color [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_line[k]  = fifo_data[k*REC_W + LINE_LSB  +: LINE_LEN];
    assign ch_col[k]   = fifo_data[k*REC_W + COL_LSB   +: COL_LEN];
    assign ch_color[k] = fifo_data[k*REC_W + COLOR_LSB +: C_MST_DWIDTH];
  end

  logic [2:0]              r_state;
  logic [IDX_W-1:0]        r_ptr;
  logic [IDX_W-1:0]        r_gnt;
  logic [LINE_LEN-1:0]     r_line;
  logic [COL_LEN-1:0]      r_col;
  logic [C_MST_DWIDTH-1:0] r_color;
  logic [RTY_W-1:0]        r_retry;
  logic [15:0]             r_pix;
  logic [15:0]             r_drop;
  logic                    r_mst_reset;

  logic [NUM_CH-1:0] w_grant;
  logic [IDX_W-1:0]  w_idx;
  logic              w_any;

  fbw_rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .req   (~fifo_empty),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  // A completion only counts when it lands in REQ together with CmdAck or in WAIT_CMPLT.
  resolve_e w_res;
  always_comb begin
    w_res = RES_NONE;
    if ((r_state == S_REQ && plb.Bus2IP_Mst_CmdAck && plb.Bus2IP_Mst_Cmplt) ||
        (r_state == S_WAIT_CMPLT && plb.Bus2IP_Mst_Cmplt)) begin
      if (plb.Bus2IP_Mst_Error)
        w_res = RES_DROP;
      else if (plb.Bus2IP_Mst_Rearbitrate || plb.Bus2IP_Mst_Cmd_Timeout)
        w_res = (r_retry < RTY_W'(MAX_RETRY)) ? RES_RETRY : RES_DROP;
      else
        w_res = RES_OK;
    end
  end

  always_ff @(posedge PLB_clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= IDX_W'(NUM_CH - 1);
      r_gnt       <= '0;
      r_line      <= '0;
      r_col       <= '0;
      r_color     <= '0;
      r_retry     <= '0;
      r_pix       <= '0;
      r_drop      <= '0;
      r_mst_reset <= 1'b1;
    end else begin
      r_mst_reset <= (r_state == S_RECOVER);
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_idx;
            r_state <= S_POP;
          end
        end
        S_POP: begin
          r_ptr   <= r_gnt;
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          r_line  <= ch_line[r_gnt];
          r_col   <= ch_col[r_gnt];
          r_color <= ch_color[r_gnt];
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (plb.Bus2IP_Mst_CmdAck && !plb.Bus2IP_Mst_Cmplt)
            r_state <= S_WAIT_CMPLT;
        end
        S_WAIT_CMPLT: ;
        S_RECOVER: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase

      case (w_res)
        RES_OK: begin
          if (r_pix != 16'hFFFF) r_pix <= r_pix + 16'd1;
          r_retry <= '0;
          r_state <= S_IDLE;
        end
        RES_RETRY: begin
          r_retry <= r_retry + RTY_W'(1);
          r_state <= S_REQ;
        end
        RES_DROP: begin
          if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
          r_retry <= '0;
          r_state <= S_RECOVER;
        end
        default: ;
      endcase
    end
  end

  assign fifo_rd_en           = (r_state == S_POP) ? (NUM_CH'(1) << r_gnt) : '0;
  assign plb.IP2Bus_MstRd_Req = 1'b0;
  assign plb.IP2Bus_MstWr_Req = (r_state == S_REQ);
  assign plb.IP2Bus_Mst_Addr  = {FB_BASE_ADDR, r_line, r_col, 2'b00};
  assign plb.IP2Bus_Mst_BE    = '1;
  assign plb.IP2Bus_Mst_Lock  = 1'b0;
  assign plb.IP2Bus_Mst_Reset = r_mst_reset;
  assign plb.IP2Bus_MstWr_d   = r_color;
  assign pix_count            = r_pix;
  assign drop_count           = r_drop;
  assign state                = r_state;

  logic unused_ok;
  assign unused_ok = ^{fifo_data, w_grant, plb.Bus2IP_MstRd_d,
                       plb.Bus2IP_MstRd_src_rdy_n, plb.Bus2IP_MstWr_dst_rdy_n};

endmodule
`default_nettype wire
